// File: rtl/lut_i2c_config_seq_if.sv
// Bus bundle between the configuration sequencer, its register lookup
// table and the I2C master. The master modport is the sequencer side.
interface lut_i2c_config_seq_if;
  logic [9:0]  lut_index;
  logic [31:0] lut_data;
  logic        i2c_write_req;
  logic [7:0]  i2c_slave_addr;
  logic [15:0] i2c_reg_addr;
  logic [7:0]  i2c_reg_data;
  logic        i2c_write_ack;
  logic        i2c_nack;
  logic        config_done;
  logic        config_error;

  modport master (
    output lut_index,
    input  lut_data,
    output i2c_write_req,
    output i2c_slave_addr,
    output i2c_reg_addr,
    output i2c_reg_data,
    input  i2c_write_ack,
    input  i2c_nack,
    output config_done,
    output config_error
  );

  modport slave (
    input  lut_index,
    output lut_data,
    input  i2c_write_req,
    input  i2c_slave_addr,
    input  i2c_reg_addr,
    input  i2c_reg_data,
    output i2c_write_ack,
    output i2c_nack,
    input  config_done,
    input  config_error
  );
endinterface

// File: rtl/lut_i2c_config_seq.sv
// Table-driven I2C register configuration sequencer. Walks a register
// lookup table from index 0, issuing one I2C write per entry with a
// bounded number of retries on NACK, until a terminator entry (0xFF device
// address) ends the sequence successfully or an error aborts it.
module lut_i2c_config_seq #(
  parameter logic [19:0] INIT_DELAY = 20'd1000000,
  parameter logic [15:0] GAP_CYCLES = 16'd1000,
  parameter logic [2:0]  MAX_RETRY  = 3'd3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  lut_i2c_config_seq_if.master        cfg_if
);

  typedef enum logic [2:0] {
    INIT_WAIT = 3'd0,
    FETCH     = 3'd1,
    CHECK     = 3'd2,
    REQ       = 3'd3,
    WAIT_ACK  = 3'd4,
    GAP       = 3'd5,
    DONE      = 3'd6,
    ERROR     = 3'd7
  } state_e;

  state_e      state_q, state_d;
  logic [19:0] init_cnt_q, init_cnt_d;
  logic [15:0] gap_cnt_q, gap_cnt_d;
  logic [2:0]  attempt_q, attempt_d;
  // Set while the current entry is being re-issued after a NACK, so the
  // re-fetch does not reset the attempt count of that entry.
  logic        retry_q, retry_d;
  logic [9:0]  index_q, index_d;
  logic [7:0]  slave_q, slave_d;
  logic [15:0] reg_addr_q, reg_addr_d;
  logic [7:0]  reg_data_q, reg_data_d;
  logic        req_q, req_d;
  logic        done_q, done_d;
  logic        error_q, error_d;

  logic        init_last_s;
  logic        gap_last_s;
  logic [2:0]  attempt_inc_s;

  // Widened compares so a zero parameter still yields a single-cycle wait.
  assign init_last_s   = ({1'b0, init_cnt_q} + 21'd1) >= {1'b0, INIT_DELAY};
  assign gap_last_s    = ({1'b0, gap_cnt_q} + 17'd1) >= {1'b0, GAP_CYCLES};
  assign attempt_inc_s = attempt_q + 3'd1;

  // Next-state and next-output logic of the sequencer FSM.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    attempt_d  = attempt_q;
    retry_d    = retry_q;
    index_d    = index_q;
    slave_d    = slave_q;
    reg_addr_d = reg_addr_q;
    reg_data_d = reg_data_q;
    req_d      = req_q;
    case (state_q)
      INIT_WAIT: begin
        if (init_last_s) begin
          init_cnt_d = 20'd0;
          state_d    = FETCH;
        end else begin
          init_cnt_d = init_cnt_q + 20'd1;
        end
      end
      FETCH: begin
        state_d = CHECK;
      end
      CHECK: begin
        if (cfg_if.lut_data[31:24] == 8'hFF) begin
          state_d = DONE;
        end else if (cfg_if.lut_data[31:24] == 8'h00) begin
          state_d = ERROR;
        end else begin
          slave_d    = cfg_if.lut_data[31:24];
          reg_addr_d = cfg_if.lut_data[23:8];
          reg_data_d = cfg_if.lut_data[7:0];
          attempt_d  = retry_q ? attempt_q : 3'd0;
          retry_d    = 1'b0;
          req_d      = 1'b1;
          state_d    = REQ;
        end
      end
      REQ: begin
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (cfg_if.i2c_write_ack) begin
          req_d = 1'b0;
          if (!cfg_if.i2c_nack) begin
            if (index_q == 10'd1023) begin
              state_d = ERROR;
            end else begin
              index_d   = index_q + 10'd1;
              gap_cnt_d = 16'd0;
              state_d   = GAP;
            end
          end else begin
            attempt_d = attempt_inc_s;
            if (attempt_inc_s < MAX_RETRY) begin
              retry_d   = 1'b1;
              gap_cnt_d = 16'd0;
              state_d   = GAP;
            end else begin
              state_d = ERROR;
            end
          end
        end else begin
          state_d = WAIT_ACK;
        end
      end
      GAP: begin
        if (gap_last_s) begin
          gap_cnt_d = 16'd0;
          state_d   = FETCH;
        end else begin
          gap_cnt_d = gap_cnt_q + 16'd1;
        end
      end
      DONE: begin
        state_d = DONE;
      end
      ERROR: begin
        state_d = ERROR;
      end
      default: begin
        req_d   = 1'b0;
        state_d = ERROR;
      end
    endcase
    done_d  = (state_d == DONE);
    error_d = (state_d == ERROR);
  end

  // State, counter and registered-output update with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= INIT_WAIT;
      init_cnt_q <= 20'd0;
      gap_cnt_q  <= 16'd0;
      attempt_q  <= 3'd0;
      retry_q    <= 1'b0;
      index_q    <= 10'd0;
      slave_q    <= 8'd0;
      reg_addr_q <= 16'd0;
      reg_data_q <= 8'd0;
      req_q      <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      attempt_q  <= attempt_d;
      retry_q    <= retry_d;
      index_q    <= index_d;
      slave_q    <= slave_d;
      reg_addr_q <= reg_addr_d;
      reg_data_q <= reg_data_d;
      req_q      <= req_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign cfg_if.lut_index      = index_q;
  assign cfg_if.i2c_write_req  = req_q;
  assign cfg_if.i2c_slave_addr = slave_q;
  assign cfg_if.i2c_reg_addr   = reg_addr_q;
  assign cfg_if.i2c_reg_data   = reg_data_q;
  assign cfg_if.config_done    = done_q;
  assign cfg_if.config_error   = error_q;

endmodule

// File: tb/tb_lut_i2c_config_seq.sv
// Bench for lut_i2c_config_seq: table-driven scenarios against a modelled
// lookup table and I2C master, plus directed reset and spurious-ack sequences.
module tb_lut_i2c_config_seq;

  localparam int ACK_LAT = 10;

  logic clk;
  logic rst_n;
  logic master_en;
  logic m_ack, m_nack, s_ack;
  logic [31:0] lut_mem [0:1023];

  int tests = 0;
  int fails = 0;
  int log_base = 0;
  int nack_target = 0;
  int stab_err = 0;
  int excl_err = 0;

  typedef struct {
    logic [9:0]  idx;
    logic [7:0]  sa;
    logic [15:0] ra;
    logic [7:0]  rd;
  } rq_t;
  rq_t req_log [$];

  typedef struct {
    int         tbl;
    int         nacks;
    int         exp_reqs;
    logic       exp_done;
    logic       exp_err;
    logic [9:0] exp_idx;
    int         exp_idx0;
  } vec_t;
  vec_t vecs [6];

  lut_i2c_config_seq_if bus ();

  assign bus.lut_data      = lut_mem[bus.lut_index];
  assign bus.i2c_write_ack = m_ack | s_ack;
  assign bus.i2c_nack      = m_nack;

  lut_i2c_config_seq #(
    .INIT_DELAY(20'd5),
    .GAP_CYCLES(16'd2),
    .MAX_RETRY (3'd3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cfg_if(bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Done and error must never be seen together.
  always @(negedge clk) begin
    if (bus.config_done && bus.config_error) excl_err++;
  end

  // I2C master model: acks each request ACK_LAT cycles after it appears,
  // NACKing the first nack_target requests of the scenario.
  initial begin : master
    rq_t e;
    logic aborted;
    int n;
    m_ack  = 1'b0;
    m_nack = 1'b0;
    forever begin
      @(negedge clk);
      if (master_en && rst_n && bus.i2c_write_req) begin
        e.idx = bus.lut_index;
        e.sa  = bus.i2c_slave_addr;
        e.ra  = bus.i2c_reg_addr;
        e.rd  = bus.i2c_reg_data;
        req_log.push_back(e);
        aborted = 1'b0;
        for (int k = 0; k < ACK_LAT - 1; k++) begin
          @(negedge clk);
          if (!rst_n || !master_en) begin
            aborted = 1'b1;
            break;
          end
          if (!bus.i2c_write_req || bus.i2c_slave_addr != e.sa ||
              bus.i2c_reg_addr != e.ra || bus.i2c_reg_data != e.rd)
            stab_err++;
        end
        if (!aborted) begin
          n = req_log.size() - log_base;
          m_ack  = 1'b1;
          m_nack = (n <= nack_target);
          @(negedge clk);
          m_ack  = 1'b0;
          m_nack = 1'b0;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic load_tbl(input int t);
    for (int i = 0; i < 1024; i++) lut_mem[i] = 32'h0000_0000;
    case (t)
      0: begin
        lut_mem[0] = 32'h7830_0802;
        lut_mem[1] = 32'h7830_0911;
        lut_mem[2] = 32'h7830_0A22;
        lut_mem[3] = 32'hFF00_0000;
      end
      1: begin
        lut_mem[0] = 32'h4212_3401;
        lut_mem[1] = 32'h4212_3502;
        lut_mem[2] = 32'h0011_2233;
      end
      2: begin
        lut_mem[0] = 32'hFF12_3456;
      end
      3: begin
        for (int i = 0; i < 1024; i++) begin
          lut_mem[i] = {8'h50, 6'd0, i[9:0], i[7:0]};
        end
      end
      default: begin
        lut_mem[0] = 32'hFF00_0000;
      end
    endcase
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    log_base = req_log.size();
    rst_n = 1'b1;
  endtask

  task automatic run_vec(input int vi, input vec_t v);
    int cyc;
    int nreq;
    int n0;
    int bad;
    int s0;
    load_tbl(v.tbl);
    nack_target = v.nacks;
    master_en = 1'b1;
    s0 = stab_err;
    apply_reset();
    cyc = 0;
    while (!(bus.config_done || bus.config_error) && cyc < 40000) begin
      @(negedge clk);
      cyc++;
    end
    check($sformatf("v%0d_timeout", vi), (cyc < 40000) ? 32'd1 : 32'd0, 32'd1);
    repeat (40) @(negedge clk);
    nreq = req_log.size() - log_base;
    n0 = 0;
    bad = 0;
    for (int i = log_base; i < req_log.size(); i++) begin
      if (req_log[i].idx == 10'd0) n0++;
      if ({req_log[i].sa, req_log[i].ra, req_log[i].rd} != lut_mem[req_log[i].idx]) bad++;
    end
    check($sformatf("v%0d_reqs", vi), nreq, v.exp_reqs);
    check($sformatf("v%0d_idx0_reqs", vi), n0, v.exp_idx0);
    check($sformatf("v%0d_fields", vi), bad, 32'd0);
    check($sformatf("v%0d_done", vi), {31'd0, bus.config_done}, {31'd0, v.exp_done});
    check($sformatf("v%0d_error", vi), {31'd0, bus.config_error}, {31'd0, v.exp_err});
    check($sformatf("v%0d_index", vi), {22'd0, bus.lut_index}, {22'd0, v.exp_idx});
    check($sformatf("v%0d_stable", vi), stab_err - s0, 32'd0);
    if (v.tbl == 0 && nreq > 0)
      check($sformatf("v%0d_first_fields", vi),
            {req_log[log_base].sa, req_log[log_base].ra, req_log[log_base].rd}, 32'h7830_0802);
  endtask

  initial begin : main
    int cyc;
    vecs[0] = '{tbl: 0, nacks: 0, exp_reqs: 3,    exp_done: 1'b1, exp_err: 1'b0, exp_idx: 10'd3,    exp_idx0: 1};
    vecs[1] = '{tbl: 0, nacks: 2, exp_reqs: 5,    exp_done: 1'b1, exp_err: 1'b0, exp_idx: 10'd3,    exp_idx0: 3};
    vecs[2] = '{tbl: 0, nacks: 3, exp_reqs: 3,    exp_done: 1'b0, exp_err: 1'b1, exp_idx: 10'd0,    exp_idx0: 3};
    vecs[3] = '{tbl: 1, nacks: 0, exp_reqs: 2,    exp_done: 1'b0, exp_err: 1'b1, exp_idx: 10'd2,    exp_idx0: 1};
    vecs[4] = '{tbl: 2, nacks: 0, exp_reqs: 0,    exp_done: 1'b1, exp_err: 1'b0, exp_idx: 10'd0,    exp_idx0: 0};
    vecs[5] = '{tbl: 3, nacks: 0, exp_reqs: 1024, exp_done: 1'b0, exp_err: 1'b1, exp_idx: 10'd1023, exp_idx0: 1};

    rst_n = 1'b0;
    master_en = 1'b0;
    s_ack = 1'b0;
    load_tbl(0);
    #3;
    check("rst_index", {22'd0, bus.lut_index}, 32'd0);
    check("rst_req", {31'd0, bus.i2c_write_req}, 32'd0);
    check("rst_fields", {bus.i2c_slave_addr, bus.i2c_reg_addr, bus.i2c_reg_data}, 32'd0);
    check("rst_done", {31'd0, bus.config_done}, 32'd0);
    check("rst_error", {31'd0, bus.config_error}, 32'd0);

    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    // Reset pulsed while a write request is outstanding.
    load_tbl(0);
    nack_target = 0;
    master_en = 1'b1;
    apply_reset();
    cyc = 0;
    while (!bus.i2c_write_req && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("mid_req_seen", {31'd0, bus.i2c_write_req}, 32'd1);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_req_drop", {31'd0, bus.i2c_write_req}, 32'd0);
    repeat (12) @(negedge clk);
    log_base = req_log.size();
    rst_n = 1'b1;
    cyc = 0;
    while (!bus.i2c_write_req && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("mid_restart_latency", cyc, 32'd7);
    check("mid_restart_index", {22'd0, bus.lut_index}, 32'd0);
    check("mid_restart_addr", {24'd0, bus.i2c_slave_addr}, 32'h78);

    // Spurious acks during INIT_WAIT and GAP, with the bench acking by hand.
    master_en = 1'b0;
    repeat (15) @(negedge clk);
    apply_reset();
    @(negedge clk);
    s_ack = 1'b1;
    @(negedge clk);
    s_ack = 1'b0;
    cyc = 2;
    while (!bus.i2c_write_req && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("spur_init_latency", cyc, 32'd7);
    check("spur_init_index", {22'd0, bus.lut_index}, 32'd0);
    repeat (3) @(negedge clk);
    check("spur_req_hold", {31'd0, bus.i2c_write_req}, 32'd1);
    s_ack = 1'b1;
    @(negedge clk);
    check("spur_req_drop", {31'd0, bus.i2c_write_req}, 32'd0);
    check("spur_index_adv", {22'd0, bus.lut_index}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    s_ack = 1'b0;
    check("spur_gap_index", {22'd0, bus.lut_index}, 32'd1);
    cyc = 3;
    while (!bus.i2c_write_req && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("spur_gap_latency", cyc, 32'd5);
    check("spur_next_reg", {16'd0, bus.i2c_reg_addr}, 32'h3009);

    check("done_error_exclusive", excl_err, 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
